// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a DEPTH-entry FIFO; frames start one cycle after the pop and tx is registered.
// No backpressure: a send while full is dropped and latched in a sticky overflow flag.

module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == LW'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
endmodule

module uart_tx_fifo #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int CLK_DIV = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        data,
    input  logic                     send,
    input  logic                     parity_en,
    input  logic [1:0]               parity_mode,
    input  logic                     stop_bit_size,
    input  logic                     clr_ovf,
    output logic                     tx,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BW    = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state, state_nx;
    logic [DIV_W-1:0]  div, div_nx;
    logic [BW-1:0]     bit_idx, bit_nx;
    logic              stop_idx, stop_nx;
    logic [DATA_W-1:0] shreg, sh_nx;
    logic              par_en_q, par_bit_q, two_stop_q;
    logic              pop, push, drop, bit_end, par_bit, tx_nx;
    logic [DATA_W-1:0] head;

    assign push = send & (~full | pop);
    assign drop = send & full & ~pop;

    sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (data),
        .pop      (pop),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    always_comb begin
        case (parity_mode)
            2'b11:   par_bit = ~(^head);
            2'b10:   par_bit = ^head;
            2'b01:   par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    assign bit_end = (div == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_nx = state;
        div_nx   = (state == IDLE) ? '0 : div + DIV_W'(1);
        bit_nx   = bit_idx;
        stop_nx  = stop_idx;
        sh_nx    = shreg;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = START;
                    sh_nx    = head;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx = DATA;
                    div_nx   = '0;
                    bit_nx   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_nx = '0;
                    sh_nx  = shreg >> 1;
                    if (bit_idx == BW'(DATA_W - 1)) begin
                        state_nx = par_en_q ? PARITY : STOP;
                        stop_nx  = 1'b0;
                    end else begin
                        bit_nx = bit_idx + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nx = STOP;
                    div_nx   = '0;
                    stop_nx  = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    div_nx = '0;
                    if (two_stop_q && !stop_idx) begin
                        stop_nx = 1'b1;
                    end else if (!empty) begin
                        // Back-to-back: next frame starts with no idle bit.
                        pop      = 1'b1;
                        state_nx = START;
                        sh_nx    = head;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // tx is registered from the next-state view so it lines up with busy.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = sh_nx[0];
            PARITY:  tx_nx = par_bit_q;
            default: tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx         <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            state    <= state_nx;
            div      <= div_nx;
            bit_idx  <= bit_nx;
            stop_idx <= stop_nx;
            shreg    <= sh_nx;
            tx       <= tx_nx;
            if (pop) begin
                par_en_q   <= parity_en;
                par_bit_q  <= par_bit;
                two_stop_q <= stop_bit_size;
            end
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DATA_W=8, DEPTH=4, CLK_DIV=16); samples tx at bit centres.
module tb_uart_tx_fifo;
    localparam int DW  = 8;
    localparam int DEP = 4;
    localparam int CD  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       send, parity_en, stop_bit_size, clr_ovf;
    logic [1:0] parity_mode;
    logic       tx, busy, full, empty, overflow;
    logic [2:0] level;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(.DATA_W(DW), .DEPTH(DEP), .CLK_DIV(CD)) dut (
        .clk           (clk),
        .rst           (rst),
        .data          (data),
        .send          (send),
        .parity_en     (parity_en),
        .parity_mode   (parity_mode),
        .stop_bit_size (stop_bit_size),
        .clr_ovf       (clr_ovf),
        .tx            (tx),
        .busy          (busy),
        .full          (full),
        .empty         (empty),
        .level         (level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(tx), 32'(0));
    endtask

    // Called at the first negedge of START; returns at the negedge just after the frame.
    task automatic capture(input int nbits, output logic [15:0] bits, output int bc);
        bits = '0;
        bc   = 0;
        for (int i = 0; i < nbits * CD; i++) begin
            if (i % CD == CD / 2) bits[i / CD] = tx;
            if (busy) bc++;
            @(negedge clk);
        end
    endtask

    logic [15:0] bits;
    int          bc;
    int          lowcnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; send = 1'b0; data = '0; parity_en = 1'b0;
        parity_mode = 2'b00; stop_bit_size = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_full", 32'(full), 32'(0));
        check("rst_level", 32'(level), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        rst = 1'b0;

        // 8'hAA, odd parity, one stop bit
        @(negedge clk);
        parity_en = 1'b1; parity_mode = 2'b11; stop_bit_size = 1'b0;
        data = 8'hAA; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("a_level", 32'(level), 32'(1));
        wait_start("a_start");
        capture(11, bits, bc);
        check("a_bits", 32'(bits), 32'({1'b1, 1'b1, 8'hAA, 1'b0}));
        check("a_busy_len", 32'(bc), 32'(176));
        check("a_idle_busy", 32'(busy), 32'(0));
        check("a_idle_tx", 32'(tx), 32'(1));

        // 8'h55 then 8'h0F, even parity, two stop bits, back-to-back
        parity_mode = 2'b10; stop_bit_size = 1'b1; data = 8'h55; send = 1'b1;
        @(negedge clk);
        data = 8'h0F;
        @(negedge clk);
        send = 1'b0;
        wait_start("b_start");
        capture(12, bits, bc);
        check("b1_bits", 32'(bits), 32'({2'b11, 1'b0, 8'h55, 1'b0}));
        check("b1_busy_len", 32'(bc), 32'(192));
        check("b_gap_tx", 32'(tx), 32'(0));
        check("b_gap_busy", 32'(busy), 32'(1));
        capture(12, bits, bc);
        check("b2_bits", 32'(bits), 32'({2'b11, 1'b0, 8'h0F, 1'b0}));
        check("b2_busy_len", 32'(bc), 32'(192));
        check("b_idle_busy", 32'(busy), 32'(0));

        // Mark frame, then mode switched mid-frame to space for the next word
        stop_bit_size = 1'b0; parity_mode = 2'b01; data = 8'h00; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_start("c_start");
        parity_mode = 2'b00; send = 1'b1;
        fork
            capture(11, bits, bc);
            begin
                @(negedge clk);
                send = 1'b0;
            end
        join
        check("c_mark_bits", 32'(bits), 32'({1'b1, 1'b1, 8'h00, 1'b0}));
        check("c_mark_len", 32'(bc), 32'(176));
        check("c_gap_tx", 32'(tx), 32'(0));
        capture(11, bits, bc);
        check("c_space_bits", 32'(bits), 32'({1'b1, 1'b0, 8'h00, 1'b0}));
        check("c_space_len", 32'(bc), 32'(176));
        check("c_idle_busy", 32'(busy), 32'(0));

        // Six pushes: one popped, four stored, sixth dropped
        parity_en = 1'b0; parity_mode = 2'b00; stop_bit_size = 1'b0;
        data = 8'h3C; send = 1'b1;
        @(negedge clk); data = 8'h00;
        @(negedge clk); data = 8'h11;
        @(negedge clk); data = 8'h22;
        @(negedge clk); data = 8'h33;
        @(negedge clk); data = 8'h44;
        @(negedge clk);
        check("d_level", 32'(level), 32'(4));
        check("d_full", 32'(full), 32'(1));
        check("d_ovf", 32'(overflow), 32'(1));
        data = 8'hEE; clr_ovf = 1'b1;
        @(negedge clk);
        check("d_drop_and_clr", 32'(overflow), 32'(1));
        send = 1'b0;
        @(negedge clk);
        check("d_clr", 32'(overflow), 32'(0));
        clr_ovf = 1'b0;
        // Land a send on the last STOP cycle of frame 8'h3C, where a pop frees a slot.
        repeat (153) @(negedge clk);
        data = 8'h66; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("d_full_pop_level", 32'(level), 32'(4));
        check("d_full_pop_ovf", 32'(overflow), 32'(0));
        check("d_b2b_tx", 32'(tx), 32'(0));
        check("d_b2b_busy", 32'(busy), 32'(1));

        // Reset in the middle of DATA bit 3 of frame 8'h00
        repeat (70) @(negedge clk);
        check("e_pre_rst_tx", 32'(tx), 32'(0));
        rst = 1'b1;
        #1;
        check("e_rst_tx", 32'(tx), 32'(1));
        check("e_rst_busy", 32'(busy), 32'(0));
        check("e_rst_level", 32'(level), 32'(0));
        check("e_rst_empty", 32'(empty), 32'(1));
        @(negedge clk);
        rst = 1'b0;
        bc = 0; lowcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) bc++;
            if (!tx) lowcnt++;
        end
        check("e_no_resume_busy", 32'(bc), 32'(0));
        check("e_no_resume_tx", 32'(lowcnt), 32'(0));

        // Send on the very first edge after reset release; no parity, 160 cycles
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; data = 8'hC3; send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("f_first_edge", 32'(level), 32'(1));
        wait_start("f_start");
        capture(10, bits, bc);
        check("f_bits", 32'(bits), 32'({1'b1, 8'hC3, 1'b0}));
        check("f_busy_len", 32'(bc), 32'(160));
        check("f_idle_busy", 32'(busy), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
